// File: rtl/baser_block_lock_if.sv
// ---------------------------------------------------------------------------
// baser_block_lock_if
//   Bundles the per-lane sync-header inputs and the lock/slip status outputs
//   of the multi-lane 64b/66b block-lock controller.
//
//   hdr_valid      NUM_LANES        a sync header is present this cycle
//   hdr            2*NUM_LANES      sync header, lane i at [2i+1:2i]
//   pma_slip       NUM_LANES        one-cycle bit-slip request to the PMA
//   block_lock     NUM_LANES        per-lane lock status
//   all_lock       1                registered AND of block_lock
//   slip_cnt       CNT_W*NUM_LANES  saturating slips issued, lane i at [CNT_W*i +: CNT_W]
//   lock_loss_cnt  CNT_W*NUM_LANES  saturating locked->unlocked transitions
//
//   master: the gearbox side that supplies headers and watches status.
//   slave : the block-lock controller itself.
// ---------------------------------------------------------------------------
interface baser_block_lock_if #(
    parameter int NUM_LANES = 4,
    parameter int CNT_W     = 16
);
    logic [NUM_LANES-1:0]       hdr_valid;
    logic [2*NUM_LANES-1:0]     hdr;
    logic [NUM_LANES-1:0]       pma_slip;
    logic [NUM_LANES-1:0]       block_lock;
    logic                       all_lock;
    logic [CNT_W*NUM_LANES-1:0] slip_cnt;
    logic [CNT_W*NUM_LANES-1:0] lock_loss_cnt;

    modport master (
        output hdr_valid, hdr,
        input  pma_slip, block_lock, all_lock, slip_cnt, lock_loss_cnt
    );

    modport slave (
        input  hdr_valid, hdr,
        output pma_slip, block_lock, all_lock, slip_cnt, lock_loss_cnt
    );
endinterface

// File: rtl/baser_block_lock.sv
// ---------------------------------------------------------------------------
// baser_block_lock
//   Multi-lane 64b/66b block-lock controller for the 10GBASE-R receive path.
//   Each lane checks its 2-bit sync headers, runs a hunt/lock state machine
//   and pulses pma_slip to bit-slip the PMA until block boundaries are found.
//
//   Parameters
//     NUM_LANES  independent lanes (1..16)
//     LOCK_CNT   consecutive valid headers needed to gain lock
//     WINDOW     header window length while locked
//     BAD_MAX    invalid headers within one window that drop lock (<= WINDOW)
//     SLIP_WAIT  cycles headers are ignored after a slip pulse (>= 1)
//     CNT_W      width of each statistics counter (16 in the receive path)
//
//   Ports
//     clk  PMA rx parallel clock
//     rst  synchronous, active-high reset
//     bl   baser_block_lock_if.slave (headers in, slip/lock/statistics out)
//
//   All outputs are registered.
// ---------------------------------------------------------------------------
module baser_block_lock #(
    parameter int NUM_LANES = 4,
    parameter int LOCK_CNT  = 64,
    parameter int WINDOW    = 64,
    parameter int BAD_MAX   = 16,
    parameter int SLIP_WAIT = 32,
    parameter int CNT_W     = 16
) (
    input  logic               clk,
    input  logic               rst,
    baser_block_lock_if.slave  bl
);

    localparam int SH_MAX = (LOCK_CNT > WINDOW) ? LOCK_CNT : WINDOW;
    localparam int SH_W   = $clog2(SH_MAX + 1);
    localparam int BAD_W  = $clog2(BAD_MAX + 1);
    localparam int WAIT_W = $clog2(SLIP_WAIT + 1);

    typedef enum logic [1:0] {
        ST_UNLOCK = 2'd0,
        ST_LOCKED = 2'd1,
        ST_SLIP   = 2'd2,
        ST_WAIT   = 2'd3
    } state_t;

    // Statistics counters stick at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    logic [NUM_LANES-1:0] lock_vec;
    logic                 all_lock_q;

    for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
        state_t            state_q, state_d;
        logic [SH_W-1:0]   sh_cnt_q, sh_cnt_d;
        logic [BAD_W-1:0]  bad_cnt_q, bad_cnt_d;
        logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
        logic              slip_q, slip_d;
        logic              lock_q, lock_d;
        logic [CNT_W-1:0]  slip_cnt_q, slip_cnt_d;
        logic [CNT_W-1:0]  loss_cnt_q, loss_cnt_d;
        logic              vld;
        logic              hdr_ok;

        assign vld    = bl.hdr_valid[i];
        // 01 and 10 are the only legal sync headers.
        assign hdr_ok = bl.hdr[2*i+1] ^ bl.hdr[2*i];

        always_comb begin
            state_d    = state_q;
            sh_cnt_d   = sh_cnt_q;
            bad_cnt_d  = bad_cnt_q;
            wait_cnt_d = wait_cnt_q;
            slip_d     = 1'b0;
            lock_d     = lock_q;
            slip_cnt_d = slip_cnt_q;
            loss_cnt_d = loss_cnt_q;

            case (state_q)
                ST_UNLOCK: begin
                    lock_d = 1'b0;
                    if (vld) begin
                        if (!hdr_ok) begin
                            state_d = ST_SLIP;
                        end else if (sh_cnt_q == SH_W'(LOCK_CNT - 1)) begin
                            state_d   = ST_LOCKED;
                            sh_cnt_d  = '0;
                            bad_cnt_d = '0;
                            lock_d    = 1'b1;
                        end else begin
                            sh_cnt_d = sh_cnt_q + SH_W'(1);
                        end
                    end
                end

                ST_LOCKED: begin
                    lock_d = 1'b1;
                    if (vld) begin
                        // Loss of lock takes priority over the window rollover.
                        if (!hdr_ok && (bad_cnt_q == BAD_W'(BAD_MAX - 1))) begin
                            state_d    = ST_SLIP;
                            lock_d     = 1'b0;
                            loss_cnt_d = sat_inc(loss_cnt_q);
                        end else if (sh_cnt_q == SH_W'(WINDOW - 1)) begin
                            sh_cnt_d  = '0;
                            bad_cnt_d = '0;
                        end else begin
                            sh_cnt_d = sh_cnt_q + SH_W'(1);
                            if (!hdr_ok) begin
                                bad_cnt_d = bad_cnt_q + BAD_W'(1);
                            end
                        end
                    end
                end

                ST_SLIP: begin
                    slip_d     = 1'b1;
                    slip_cnt_d = sat_inc(slip_cnt_q);
                    wait_cnt_d = WAIT_W'(SLIP_WAIT);
                    state_d    = ST_WAIT;
                end

                ST_WAIT: begin
                    // Leaving on the edge that takes the count to zero makes the
                    // first re-examined header land SLIP_WAIT+2 cycles after the
                    // triggering one.
                    if (wait_cnt_q == WAIT_W'(1)) begin
                        wait_cnt_d = '0;
                        sh_cnt_d   = '0;
                        bad_cnt_d  = '0;
                        state_d    = ST_UNLOCK;
                    end else begin
                        wait_cnt_d = wait_cnt_q - WAIT_W'(1);
                    end
                end

                default: begin
                    state_d = ST_UNLOCK;
                    lock_d  = 1'b0;
                end
            endcase
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                state_q    <= ST_UNLOCK;
                sh_cnt_q   <= '0;
                bad_cnt_q  <= '0;
                wait_cnt_q <= '0;
                slip_q     <= 1'b0;
                lock_q     <= 1'b0;
                slip_cnt_q <= '0;
                loss_cnt_q <= '0;
            end else begin
                state_q    <= state_d;
                sh_cnt_q   <= sh_cnt_d;
                bad_cnt_q  <= bad_cnt_d;
                wait_cnt_q <= wait_cnt_d;
                slip_q     <= slip_d;
                lock_q     <= lock_d;
                slip_cnt_q <= slip_cnt_d;
                loss_cnt_q <= loss_cnt_d;
            end
        end

        assign lock_vec[i]                         = lock_q;
        assign bl.pma_slip[i]                      = slip_q;
        assign bl.slip_cnt[CNT_W*i +: CNT_W]       = slip_cnt_q;
        assign bl.lock_loss_cnt[CNT_W*i +: CNT_W]  = loss_cnt_q;
    end

    // all_lock is one register behind the per-lane lock flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            all_lock_q <= 1'b0;
        end else begin
            all_lock_q <= &lock_vec;
        end
    end

    assign bl.block_lock = lock_vec;
    assign bl.all_lock   = all_lock_q;

endmodule
